tmr_voter: RTL and testbench

//  Registered word-level majority voter for triple-redundant data lanes a/b/c.

---
 rtl/tmr_pkg.sv | 19 +
 rtl/tmr_lane_monitor.sv | 103 ++++++++++
 rtl/tmr_voter.sv | 130 +++++++++++++
 tb/tb_tmr_voter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the triple-modular-redundancy voter.
// Lane state encoding, lane indices and a 3-bit population count.
package tmr_pkg;

  typedef enum logic [1:0] {
    LS_OK      = 2'd0,
    LS_SUSPECT = 2'd1,
    LS_FAILED  = 2'd2
  } lane_state_t;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane health tracker: OK -> SUSPECT -> FAILED on consecutive mismatches.
// TMR_STICKY_FAIL_EN makes FAILED terminal until reset; otherwise agreements recover.
module tmr_lane_monitor
  import tmr_pkg::*;
#(
  parameter int FAIL_THRESH    = 3,
  parameter int RECOVER_THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic err,
  output logic failed
);

  localparam int MAX_T = (FAIL_THRESH > RECOVER_THRESH) ? FAIL_THRESH : RECOVER_THRESH;
  localparam int RUN_W = $clog2(MAX_T + 1);
  localparam logic [RUN_W-1:0] FAIL_LIM = RUN_W'(FAIL_THRESH);
`ifndef TMR_STICKY_FAIL_EN
  localparam logic [RUN_W-1:0] REC_LIM  = RUN_W'(RECOVER_THRESH);
`endif

  lane_state_t          state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [RUN_W-1:0]     run_inc;

  assign run_inc = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
  assign failed  = (state_q == LS_FAILED);

  // Next state and run counter; only accepted, correctable samples advance.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (step) begin
      case (state_q)
        LS_OK: begin
          if (err) begin
            if (FAIL_THRESH == 1) begin
              state_d = LS_FAILED;
              run_d   = {RUN_W{1'b0}};
            end else begin
              state_d = LS_SUSPECT;
              run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = LS_OK;
            run_d   = {RUN_W{1'b0}};
          end
        end
        LS_SUSPECT: begin
          if (err) begin
            if (run_inc >= FAIL_LIM) begin
              state_d = LS_FAILED;
              run_d   = {RUN_W{1'b0}};
            end else begin
              state_d = LS_SUSPECT;
              run_d   = run_inc;
            end
          end else begin
            state_d = LS_OK;
            run_d   = {RUN_W{1'b0}};
          end
        end
        LS_FAILED: begin
`ifdef TMR_STICKY_FAIL_EN
          state_d = LS_FAILED;
          run_d   = {RUN_W{1'b0}};
`else
          if (err) begin
            state_d = LS_FAILED;
            run_d   = {RUN_W{1'b0}};
          end else if (run_inc >= REC_LIM) begin
            state_d = LS_OK;
            run_d   = {RUN_W{1'b0}};
          end else begin
            state_d = LS_FAILED;
            run_d   = run_inc;
          end
`endif
        end
        default: begin
          state_d = LS_OK;
          run_d   = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      run_d   = run_q;
    end
  end

  // State and run counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LS_OK;
      run_q   <= {RUN_W{1'b0}};
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/tmr_voter.sv
// Registered word-level majority voter over three redundant lanes with lane retirement.
// Define TMR_STICKY_FAIL_EN to make a FAILED lane stay failed until reset.
module tmr_voter
  import tmr_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int FAIL_THRESH    = 3,
  parameter int RECOVER_THRESH = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       lane_err,
  output logic [2:0]       lane_fail,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [2:0]       healthy_s;
  logic [WIDTH-1:0] maj_s;
  logic [WIDTH-1:0] vote_s;
  logic             unc_s;
  logic [2:0]       err_s;
  logic [1:0]       err_pop_s;
  logic             step_s;
  logic [CNT_W+1:0] cnt_sum_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [2:0]       lane_err_q, lane_err_d;
  logic             unc_q, unc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign healthy_s = ~lane_fail;
  assign maj_s     = (a & b) | (a & c) | (b & c);

  // Vote over the currently healthy lanes; the lane states are pre-update here.
  always_comb begin
    vote_s = maj_s;
    unc_s  = 1'b0;
    case (healthy_s)
      3'b111: begin
        if ((a == b) || (a == c)) begin
          vote_s = a;
        end else if (b == c) begin
          vote_s = b;
        end else begin
          vote_s = maj_s;
          unc_s  = 1'b1;
        end
      end
      3'b011: begin vote_s = a; unc_s = (a != b); end
      3'b101: begin vote_s = a; unc_s = (a != c); end
      3'b110: begin vote_s = b; unc_s = (b != c); end
      3'b001: begin vote_s = a; unc_s = 1'b0; end
      3'b010: begin vote_s = b; unc_s = 1'b0; end
      3'b100: begin vote_s = c; unc_s = 1'b0; end
      default: begin vote_s = maj_s; unc_s = 1'b1; end
    endcase
  end

  assign err_s     = {(c != vote_s), (b != vote_s), (a != vote_s)};
  assign err_pop_s = popcount3(err_s);
  assign step_s    = in_valid & ~unc_s;
  assign cnt_sum_s = {2'b00, cnt_q} + {{CNT_W{1'b0}}, err_pop_s};

  // Output register next values; idle cycles hold the last result.
  always_comb begin
    out_valid_d = in_valid;
    y_d         = y_q;
    lane_err_d  = lane_err_q;
    unc_d       = unc_q;
    cnt_d       = cnt_q;
    if (in_valid) begin
      y_d        = vote_s;
      lane_err_d = err_s;
      unc_d      = unc_s;
      if (cnt_sum_s > {2'b00, {CNT_W{1'b1}}}) begin
        cnt_d = {CNT_W{1'b1}};
      end else begin
        cnt_d = cnt_sum_s[CNT_W-1:0];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      lane_err_q  <= 3'b000;
      unc_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      lane_err_q  <= lane_err_d;
      unc_q       <= unc_d;
      cnt_q       <= cnt_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    tmr_lane_monitor #(
      .FAIL_THRESH    (FAIL_THRESH),
      .RECOVER_THRESH (RECOVER_THRESH)
    ) u_mon (
      .clk    (clk),
      .rst    (rst),
      .step   (step_s),
      .err    (err_s[i]),
      .failed (lane_fail[i])
    );
  end

  assign out_valid     = out_valid_q;
  assign y             = y_q;
  assign lane_err      = lane_err_q;
  assign uncorrectable = unc_q;
  assign mismatch_cnt  = cnt_q;

endmodule

// File: tb/tb_tmr_voter.sv
// Scoreboard bench for tmr_voter (CNT_W=4 so counter saturation is reachable).
// Expectations follow TMR_STICKY_FAIL_EN when it is defined for the build.
module tb_tmr_voter;

`ifdef TMR_STICKY_FAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b, c;
  logic       out_valid;
  logic [7:0] y;
  logic [2:0] lane_err;
  logic [2:0] lane_fail;
  logic       uncorrectable;
  logic [3:0] mismatch_cnt;

  tmr_voter #(
    .WIDTH(8), .FAIL_THRESH(3), .RECOVER_THRESH(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .y(y), .lane_err(lane_err), .lane_fail(lane_fail),
    .uncorrectable(uncorrectable), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [2:0] err;
    logic [2:0] fail;
    logic       unc;
    logic [3:0] cnt;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                      input logic [7:0] ey, input logic [2:0] eerr, input logic [2:0] efail,
                      input logic eunc, input string nm);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; c = vc; in_valid = 1'b1;
    exp_cnt = exp_cnt + $countones(eerr);
    if (exp_cnt > 15) exp_cnt = 15;
    e.y = ey; e.err = eerr; e.fail = efail; e.unc = eunc; e.cnt = 4'(exp_cnt); e.nm = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: every presented output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.nm, "_y"},    y,             e.y);
        chk({e.nm, "_err"},  lane_err,      e.err);
        chk({e.nm, "_fail"}, lane_fail,     e.fail);
        chk({e.nm, "_unc"},  uncorrectable, e.unc);
        chk({e.nm, "_cnt"},  mismatch_cnt,  e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_lane_err", lane_err, 0);
    chk("rst_lane_fail", lane_fail, 0);
    chk("rst_unc", uncorrectable, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    rst = 1'b0;

    send(8'h5A, 8'h5A, 8'h5A, 8'h5A, 3'b000, 3'b000, 1'b0, "t1_agree");
    @(negedge clk);
    in_valid = 1'b0; a = 8'h77; b = 8'h88; c = 8'h99;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_y_hold", y, 8'h5A);
    chk("idle_cnt", mismatch_cnt, 0);
    chk("idle_fail", lane_fail, 0);

    for (int k = 0; k < 3; k++)
      send(8'hFF, 8'h11, 8'h11, 8'h11, 3'b001, (k == 2) ? 3'b001 : 3'b000, 1'b0, "t2_fail");
    for (int k = 0; k < 10; k++)
      send(8'h22, 8'h22, 8'h22, 8'h22, 3'b000,
           (STICKY || k < 3) ? 3'b001 : 3'b000, 1'b0, "t2_recover");

    send(8'h01, 8'h02, 8'h04, STICKY ? 8'h02 : 8'h00, STICKY ? 3'b101 : 3'b111,
         STICKY ? 3'b001 : 3'b000, 1'b1, "t4_unc");

    for (int k = 0; k < 3; k++)
      send(8'hFF, 8'h11, 8'h11, 8'h11, 3'b001,
           (STICKY || k == 2) ? 3'b001 : 3'b000, 1'b0, "t5_fail");
    send(8'h55, 8'h10, 8'h20, 8'h10, 3'b101, 3'b001, 1'b1, "t5_split");
    send(8'h55, 8'h30, 8'h30, 8'h30, 3'b001, 3'b001, 1'b0, "t5_agree");

    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 8'hEE; b = 8'hEE; c = 8'hEE;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; exp_cnt = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_fail", lane_fail, 0);
    chk("mid_rst_cnt", mismatch_cnt, 0);
    chk("mid_rst_y", y, 0);

    for (int k = 0; k < 14; k++)
      send(8'h00, 8'hFF, 8'hFF, 8'hFF, 3'b001, (k >= 2) ? 3'b001 : 3'b000, 1'b0, "t6_fill");
    send(8'h01, 8'h02, 8'h04, 8'h02, 3'b101, 3'b001, 1'b1, "t6_sat_over");
    for (int k = 0; k < 2; k++)
      send(8'h00, 8'hFF, 8'hFF, 8'hFF, 3'b001, 3'b001, 1'b0, "t6_sat_hold");

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
